// File: rtl/uart_boot_loader_if.sv
// rtl/uart_boot_loader_if.sv - UART byte input and instruction-memory write port bundle
interface uart_boot_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - parses SYNC/LEN/DATA/CHK frames from UART bytes into instruction memory
// Holds the CPU stopped while a frame loads and releases it only after a good checksum.
module uart_boot_loader #(
  parameter int          ADDR_WIDTH     = 8,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  uart_boot_loader_if.master      bus,
  output logic                    cpu_run_o,
  output logic                    load_busy_o,
  output logic                    load_ok_o,
  output logic                    load_err_o
);

  localparam int              TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]     MAX_LEN  = 17'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHK
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [31:0]           word_q, word_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [15:0]           widx_q, widx_d;
  logic [7:0]            chk_q, chk_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  run_q, run_d;
  logic                  busy_q, busy_d;
  logic                  ok_q, ok_d;
  logic                  err_q, err_d;
  logic                  fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      word_q  <= '0;
      bcnt_q  <= '0;
      widx_q  <= '0;
      chk_q   <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      widx_q  <= widx_d;
      chk_q   <= chk_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    widx_d  = widx_q;
    chk_d   = chk_q;
    tmo_d   = tmo_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    run_d   = run_q;
    busy_d  = busy_q;
    ok_d    = ok_q;
    err_d   = err_q;
    fail    = 1'b0;

    // An arriving byte always beats the timeout, even on the terminal count.
    if (bus.rx_valid) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (bus.rx_data == SYNC_BYTE) begin
            state_d = S_LEN_HI;
            busy_d  = 1'b1;
            run_d   = 1'b0;
            ok_d    = 1'b0;
            err_d   = 1'b0;
            chk_d   = '0;
            widx_d  = '0;
            bcnt_d  = '0;
          end
        end
        S_LEN_HI: begin
          len_d[15:8] = bus.rx_data;
          chk_d       = chk_q ^ bus.rx_data;
          state_d     = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d[7:0] = bus.rx_data;
          chk_d      = chk_q ^ bus.rx_data;
          if ({1'b0, len_q[15:8], bus.rx_data} > MAX_LEN) begin
            fail = 1'b1;
          end else if ({len_q[15:8], bus.rx_data} == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          word_d = {word_q[23:0], bus.rx_data};
          chk_d  = chk_q ^ bus.rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = widx_q[ADDR_WIDTH-1:0];
            wdata_d = word_d;
            widx_d  = widx_q + 16'd1;
            if (widx_q == len_q - 16'd1) begin
              state_d = S_CHK;
            end
          end
        end
        S_CHK: begin
          if (bus.rx_data == chk_q) begin
            state_d = S_IDLE;
            ok_d    = 1'b1;
            run_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            fail = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        fail = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    if (fail) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      busy_d  = 1'b0;
      run_d   = 1'b0;
      tmo_d   = '0;
    end
  end

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_run_o     = run_q;
  assign load_busy_o   = busy_q;
  assign load_ok_o     = ok_q;
  assign load_err_o    = err_q;

endmodule
